// File: rtl/lzc_arb_pkg.sv
// Shared types and constants for the shared first-set-bit arbiter.
package lzc_arb_pkg;

  localparam int unsigned LZC_W    = 64;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned CNT_W    = 7;
  // Widest requester ID supported (N_REQ up to 16).
  localparam int unsigned MAX_ID_W = 4;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [IDX_W-1:0]    idx;
    logic [CNT_W-1:0]    lzc;
    logic                zero;
  } lzc_rsp_t;

  // Leading-zero count from the MSB index; an all-zero word counts as fully zero.
  function automatic logic [CNT_W-1:0] idx_to_lzc(logic [IDX_W-1:0] idx, logic zero);
    return zero ? CNT_W'(LZC_W) : CNT_W'(LZC_W - 1) - CNT_W'(idx);
  endfunction

endpackage

// File: rtl/first_set_bit64.sv
// Combinational most-significant-set-bit finder for a 64-bit word.
module first_set_bit64
  import lzc_arb_pkg::*;
(
  input  logic [LZC_W-1:0] data,
  output logic [IDX_W-1:0] idx,
  output logic             zero
);

  // Ascending scan: the highest set bit is the last one to overwrite idx.
  always_comb begin
    idx = '0;
    for (int i = 0; i < LZC_W; i++) begin
      if (data[i]) idx = IDX_W'(i);
    end
  end

  assign zero = ~|data;

endmodule

// File: rtl/lzc_rr_arbiter.sv
// Round-robin arbiter: search starts at ptr, pointer moves past the winner on advance.
module lzc_rr_arbiter #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] lane;
  logic            found;

  // First requesting lane at or after ptr (cyclically) wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    lane     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      lane = ID_W'((32'(ptr_q) + i) % N_REQ);
      if (!found && req[lane]) begin
        found       = 1'b1;
        grant[lane] = 1'b1;
        grant_id    = lane;
      end
    end
  end

  // Pointer moves to winner+1 only when the grant is actually taken.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

  // Pointer register, synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/lzc_share_arbiter.sv
// Shares one first-set-bit unit between N_REQ lanes through a 2-stage elastic pipeline.
module lzc_share_arbiter
  import lzc_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*LZC_W-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [IDX_W-1:0]       rsp_idx,
  output logic [CNT_W-1:0]       rsp_lzc,
  output logic                   rsp_zero
);

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic [LZC_W-1:0] win_data;
  logic             accept;
  logic             s1_load_ok;
  logic             s2_load;

  logic             s1_valid_q, s1_valid_d;
  logic [LZC_W-1:0] s1_data_q, s1_data_d;
  logic [ID_W-1:0]  s1_id_q, s1_id_d;
  logic             s2_valid_q, s2_valid_d;
  lzc_rsp_t         s2_q, s2_d;

  logic [IDX_W-1:0] fsb_idx;
  logic             fsb_zero;
  logic             unused_id_hi;

  lzc_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .advance  (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  first_set_bit64 u_fsb (
    .data (s1_data_q),
    .idx  (fsb_idx),
    .zero (fsb_zero)
  );

  // s2 takes new data when empty or draining; s1 may load when empty or moving into s2.
  assign s2_load    = !s2_valid_q || rsp_ready;
  assign s1_load_ok = !s1_valid_q || s2_load;
  assign req_ready  = (rst_n && s1_load_ok) ? (grant & req_valid) : '0;
  assign accept     = |req_ready;
  assign win_data   = req_data[32'(grant_id) * LZC_W +: LZC_W];

  // Stage 1 next state: capture the winning lane's word and ID.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_id_d    = s1_id_q;
    if (s1_load_ok) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_data_d = win_data;
        s1_id_d   = grant_id;
      end
    end
  end

  // Stage 2 next state: register the computed result; payload only changes on real data.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d.id   = MAX_ID_W'(s1_id_q);
        s2_d.idx  = fsb_idx;
        s2_d.lzc  = idx_to_lzc(fsb_idx, fsb_zero);
        s2_d.zero = fsb_zero;
      end
    end
  end

  // Pipeline registers, synchronous active-low reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_q       <= s2_d;
    end
  end

  assign rsp_valid    = s2_valid_q;
  assign rsp_id       = s2_q.id[ID_W-1:0];
  assign rsp_idx      = s2_q.idx;
  assign rsp_lzc      = s2_q.lzc;
  assign rsp_zero     = s2_q.zero;
  assign unused_id_hi = ^s2_q.id;

endmodule

// File: tb/tb_lzc_share_arbiter.sv
// Self-checking bench for lzc_share_arbiter with a queue-based reference model.
module tb_lzc_share_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  typedef struct {
    int          id;
    logic [63:0] d;
    int          acc;
  } item_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*64-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [5:0]      rsp_idx;
  logic [6:0]      rsp_lzc;
  logic            rsp_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lzc_share_arbiter #(
    .N_REQ (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_idx   (rsp_idx),
    .rsp_lzc   (rsp_lzc),
    .rsp_zero  (rsp_zero)
  );

  // Leading zeros counted from the top, one bit at a time.
  function automatic logic [6:0] ref_lzc(input logic [63:0] d);
    int n = 0;
    while (n < 64 && d[63-n] == 1'b0) n++;
    return 7'(n);
  endfunction

  function automatic logic [5:0] ref_idx(input logic [63:0] d);
    logic [6:0] n = ref_lzc(d);
    return (n == 7'd64) ? 6'd0 : 6'(7'd63 - n);
  endfunction

  function automatic logic [63:0] rand_data();
    logic [63:0] v = {$urandom, $urandom};
    int unsigned sel = $urandom_range(0, 5);
    case (sel)
      0:       v = '0;
      1:       v = 64'h1 << $urandom_range(0, 63);
      default: v = v >> $urandom_range(0, 63);
    endcase
    return v;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Offers one word on one lane and reports the latency and response fields.
  task automatic send_one(input int lane, input logic [63:0] d, output int lat,
                          output logic [IW-1:0] id, output logic [5:0] idx,
                          output logic [6:0] lzc, output logic zero);
    bit got = 0;
    lat = -1; id = '0; idx = '0; lzc = '0; zero = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_valid[lane] = 1'b1;
    req_data[lane*64 +: 64] = d;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready[lane]) got = 1;
      else @(posedge clk);
    end
    @(posedge clk); #1;
    req_valid = '0;
    if (got) begin
      for (int k = 1; k <= 10 && lat < 0; k++) begin
        @(negedge clk);
        if (rsp_valid) begin
          lat = k; id = rsp_id; idx = rsp_idx; lzc = rsp_lzc; zero = rsp_zero;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req_valid = '1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
    end
    checks++;
    if (req_ready !== '0) begin
      errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready);
    end
    checks++;
    if ({rsp_id, rsp_idx, rsp_lzc, rsp_zero} !== 16'h0) begin
      errors++;
      $display("FAIL reset_fields: got id=%0d idx=%0d lzc=%0d zero=%b want all 0",
               rsp_id, rsp_idx, rsp_lzc, rsp_zero);
    end
    @(posedge clk); #1;
    req_valid = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int lat; logic [IW-1:0] id; logic [5:0] idx; logic [6:0] lzc; logic zero;
    send_one(0, 64'h0000_0001_0000_0000, lat, id, idx, lzc, zero);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL single_latency: got %0d want 2", lat);
    end
    checks++;
    if ({id, idx, lzc, zero} !== {2'd0, 6'd32, 7'd31, 1'b0}) begin
      errors++;
      $display("FAIL single_fields: got id=%0d idx=%0d lzc=%0d zero=%b want 0/32/31/0",
               id, idx, lzc, zero);
    end
  endtask

  task automatic test_corners();
    logic [63:0] dv [3] = '{64'h0, 64'h8000_0000_0000_0000, 64'h1};
    logic [5:0]  ei [3] = '{6'd0, 6'd63, 6'd0};
    logic [6:0]  el [3] = '{7'd64, 7'd0, 7'd63};
    logic        ez [3] = '{1'b1, 1'b0, 1'b0};
    int lat; logic [IW-1:0] id; logic [5:0] idx; logic [6:0] lzc; logic zero;
    for (int i = 0; i < 3; i++) begin
      send_one(i + 1, dv[i], lat, id, idx, lzc, zero);
      checks++;
      if (lat !== 2) begin
        errors++; $display("FAIL corner%0d_latency: got %0d want 2", i, lat);
      end
      checks++;
      if ({id, idx, lzc, zero} !== {IW'(i + 1), ei[i], el[i], ez[i]}) begin
        errors++;
        $display("FAIL corner%0d_fields: got id=%0d idx=%0d lzc=%0d zero=%b want %0d/%0d/%0d/%b",
                 i, id, idx, lzc, zero, i + 1, ei[i], el[i], ez[i]);
      end
    end
  endtask

  task automatic test_all_lanes();
    item_t q[$];
    item_t it;
    int exp_g = 0;
    int g;
    logic [N-1:0] one = 1;
    apply_reset();
    rsp_ready = 1'b1;
    for (int l = 0; l < N; l++) req_data[l*64 +: 64] = rand_data();
    req_valid = '1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== (one << exp_g)) begin
        errors++; $display("FAIL rr_order: got %b want lane %0d", req_ready, exp_g);
      end
      if (c >= 2) begin
        checks++;
        if (rsp_valid !== 1'b1) begin
          errors++; $display("FAIL rr_throughput: got rsp_valid=%b want 1 at cycle %0d", rsp_valid, c);
        end
      end
      if (rsp_valid && q.size() > 0) begin
        it = q.pop_front();
        checks++;
        if ({rsp_id, rsp_idx, rsp_lzc, rsp_zero} !==
            {IW'(it.id), ref_idx(it.d), ref_lzc(it.d), it.d == 64'h0}) begin
          errors++;
          $display("FAIL rr_rsp: got id=%0d idx=%0d lzc=%0d want id=%0d idx=%0d lzc=%0d",
                   rsp_id, rsp_idx, rsp_lzc, it.id, ref_idx(it.d), ref_lzc(it.d));
        end
      end
      g = -1;
      for (int l = 0; l < N; l++) if (req_ready[l]) g = l;
      if (g >= 0) q.push_back('{g, req_data[g*64 +: 64], c});
      exp_g = (exp_g + 1) % N;
      @(posedge clk); #1;
      if (g >= 0) req_data[g*64 +: 64] = rand_data();
    end
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    item_t q[$];
    item_t it;
    bit done [N];
    int acc_early = 0;
    int g;
    bit have = 0;
    logic [15:0] held = '0;
    apply_reset();
    for (int l = 0; l < N; l++) begin
      req_data[l*64 +: 64] = rand_data();
      done[l] = 0;
    end
    req_valid = '1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c < 5) begin
        if (req_ready != '0) acc_early++;
        if (c >= 2) begin
          checks++;
          if (req_ready !== '0) begin
            errors++; $display("FAIL bp_full_ready: got %b want 0000 at cycle %0d", req_ready, c);
          end
          checks++;
          if (rsp_valid !== 1'b1) begin
            errors++; $display("FAIL bp_rsp_held: got rsp_valid=%b want 1 at cycle %0d", rsp_valid, c);
          end
        end
        if (rsp_valid) begin
          if (!have) begin
            held = {rsp_id, rsp_idx, rsp_lzc, rsp_zero};
            have = 1;
          end else begin
            checks++;
            if ({rsp_id, rsp_idx, rsp_lzc, rsp_zero} !== held) begin
              errors++;
              $display("FAIL bp_stable: got %h want %h", {rsp_id, rsp_idx, rsp_lzc, rsp_zero}, held);
            end
          end
        end
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL bp_extra_rsp: got id=%0d want no response", rsp_id);
        end else begin
          it = q.pop_front();
          if ({rsp_id, rsp_idx, rsp_lzc, rsp_zero} !==
              {IW'(it.id), ref_idx(it.d), ref_lzc(it.d), it.d == 64'h0}) begin
            errors++;
            $display("FAIL bp_rsp: got id=%0d idx=%0d lzc=%0d want id=%0d idx=%0d lzc=%0d",
                     rsp_id, rsp_idx, rsp_lzc, it.id, ref_idx(it.d), ref_lzc(it.d));
          end
        end
      end
      g = -1;
      for (int l = 0; l < N; l++) if (req_ready[l]) g = l;
      if (g >= 0) begin
        q.push_back('{g, req_data[g*64 +: 64], c});
        done[g] = 1;
      end
      @(posedge clk); #1;
      if (g >= 0) req_valid[g] = 1'b0;
      if (c == 4) rsp_ready = 1'b1;
    end
    checks++;
    if (acc_early !== 2) begin
      errors++; $display("FAIL bp_accepts: got %0d want 2", acc_early);
    end
    checks++;
    if (q.size() != 0 || !(done[0] && done[1] && done[2] && done[3])) begin
      errors++;
      $display("FAIL bp_drain: got %0d pending, lanes done %b%b%b%b want 0 pending, 1111",
               q.size(), done[3], done[2], done[1], done[0]);
    end
    req_valid = '0;
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    for (int l = 0; l < N; l++) req_data[l*64 +: 64] = rand_data();
    req_valid = 4'b0110;
    repeat (2) @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL mid_inflight: got rsp_valid=%b want 1", rsp_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL mid_discard: got rsp_valid=%b want 0 at cycle %0d", rsp_valid, c);
      end
    end
    @(posedge clk); #1;
    req_valid = '1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL mid_ptr: got %b want 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    item_t q[$];
    item_t it;
    int ptr_m = 0;
    int accepted = 0;
    int cyc = 0;
    int wait_acc [N];
    int g, exp_g;
    bit exp_v, can_acc;
    apply_reset();
    for (int l = 0; l < N; l++) wait_acc[l] = 0;
    while (!(accepted >= 10000 && req_valid == '0 && q.size() == 0) && cyc < 60000) begin
      @(negedge clk);
      exp_v = (q.size() > 0) && (cyc >= q[0].acc + 2);
      can_acc = (req_valid != '0) && (q.size() < 2 || rsp_ready);
      checks++;
      if (rsp_valid !== exp_v) begin
        errors++; $display("FAIL rand_rsp_valid: got %b want %b at cycle %0d", rsp_valid, exp_v, cyc);
      end
      if (rsp_valid && rsp_ready && q.size() > 0) begin
        it = q.pop_front();
        checks++;
        if ({rsp_id, rsp_idx, rsp_lzc, rsp_zero} !==
            {IW'(it.id), ref_idx(it.d), ref_lzc(it.d), it.d == 64'h0}) begin
          errors++;
          $display("FAIL rand_rsp: got id=%0d idx=%0d lzc=%0d z=%b want id=%0d idx=%0d lzc=%0d",
                   rsp_id, rsp_idx, rsp_lzc, rsp_zero, it.id, ref_idx(it.d), ref_lzc(it.d));
        end
      end
      checks++;
      if (!$onehot0(req_ready)) begin
        errors++; $display("FAIL rand_onehot: got %b want at most one bit", req_ready);
      end
      checks++;
      if ((req_ready != '0) !== can_acc) begin
        errors++;
        $display("FAIL rand_accept: got ready=%b want accept=%b (pending %0d)",
                 req_ready, can_acc, q.size());
      end
      g = -1;
      for (int l = 0; l < N; l++) if (req_ready[l]) g = l;
      if (g >= 0) begin
        exp_g = -1;
        for (int k = 0; k < N; k++) begin
          if (exp_g < 0 && req_valid[(ptr_m + k) % N]) exp_g = (ptr_m + k) % N;
        end
        checks++;
        if (g !== exp_g) begin
          errors++; $display("FAIL rand_grant: got lane %0d want lane %0d", g, exp_g);
        end
        checks++;
        if (wait_acc[g] > N - 1) begin
          errors++; $display("FAIL rand_fair: got wait %0d want <= %0d", wait_acc[g], N - 1);
        end
        for (int l = 0; l < N; l++) if (l != g && req_valid[l]) wait_acc[l]++;
        wait_acc[g] = 0;
        q.push_back('{g, req_data[g*64 +: 64], cyc});
        ptr_m = (g + 1) % N;
        accepted++;
      end
      @(posedge clk); #1;
      cyc++;
      if (g >= 0) req_valid[g] = 1'b0;
      if (accepted < 10000) begin
        for (int l = 0; l < N; l++) begin
          if (!req_valid[l] && $urandom_range(0, 1) == 1) begin
            req_valid[l] = 1'b1;
            req_data[l*64 +: 64] = rand_data();
          end
        end
        rsp_ready = ($urandom_range(0, 3) != 0);
      end else begin
        rsp_ready = 1'b1;
      end
    end
    checks++;
    if (accepted < 10000 || q.size() != 0) begin
      errors++;
      $display("FAIL rand_complete: got %0d accepted, %0d pending want >=10000, 0",
               accepted, q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_corners();
    test_all_lanes();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
